fwd_hazard_ctrl: RTL and testbench



---
 rtl/fwd_hazard_if.sv | 33 +++
 rtl/fwd_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_if.sv
// ID-side request and EX operand-mux select bundle for the forwarding/hazard controller.
// The pipeline (master) presents the ID instruction and flush; the controller (slave) returns the selects and stall.
interface fwd_hazard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              flush;
    logic              stall;
    logic              ex_bubble;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread, flush,
        input  stall, ex_bubble, fwd_a_sel, fwd_b_sel, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread, flush,
        output stall, ex_bubble, fwd_a_sel, fwd_b_sel, stall_count
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select generator and load-use hazard detector for a 5-stage pipeline.
// Tracks shadow destination info for EX and MEM; selects are registered, stall is combinational.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic        clk,
    input logic        rst,
    fwd_hazard_if.slave bus
);
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic              ex_v, ex_rw, ex_mr;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_v, mem_rw;
    logic [REG_AW-1:0] mem_rd;

    logic              ex_bubble;
    logic [1:0]        fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0]  stall_count;

    logic              stall_c;
    logic [1:0]        sel_a_c, sel_b_c;

    // Youngest producer wins: EX is checked before MEM; x0 never produces.
    function automatic logic [1:0] pick_sel(
        input logic              use_r,
        input logic [REG_AW-1:0] r,
        input logic              exv, exrw,
        input logic [REG_AW-1:0] exrd,
        input logic              memv, memrw,
        input logic [REG_AW-1:0] memrd
    );
        logic [1:0] s;
        s = SEL_RF;
        if (use_r && r != '0) begin
            if (exv && exrw && exrd == r)
                s = SEL_EX;
            else if (memv && memrw && memrd == r)
                s = SEL_MEM;
        end
        return s;
    endfunction

    always_comb begin
        stall_c = 1'b0;
        if (!rst && bus.id_valid && !bus.flush && ex_v && ex_mr) begin
            stall_c = (bus.id_use_rs1 && ex_rd == bus.id_rs1 && bus.id_rs1 != '0) ||
                      (bus.id_use_rs2 && ex_rd == bus.id_rs2 && bus.id_rs2 != '0);
        end
        sel_a_c = pick_sel(bus.id_use_rs1, bus.id_rs1, ex_v, ex_rw, ex_rd, mem_v, mem_rw, mem_rd);
        sel_b_c = pick_sel(bus.id_use_rs2, bus.id_rs2, ex_v, ex_rw, ex_rd, mem_v, mem_rw, mem_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v        <= 1'b0;
            ex_rw       <= 1'b0;
            ex_mr       <= 1'b0;
            ex_rd       <= '0;
            mem_v       <= 1'b0;
            mem_rw      <= 1'b0;
            mem_rd      <= '0;
            fwd_a_sel   <= SEL_RF;
            fwd_b_sel   <= SEL_RF;
            ex_bubble   <= 1'b1;
            stall_count <= '0;
        end else begin
            // The instruction leaving EX always advances, even on flush or stall.
            mem_v  <= ex_v;
            mem_rw <= ex_rw;
            mem_rd <= ex_rd;
            if (bus.flush || stall_c) begin
                ex_v      <= 1'b0;
                ex_rw     <= 1'b0;
                ex_mr     <= 1'b0;
                ex_rd     <= '0;
                fwd_a_sel <= SEL_RF;
                fwd_b_sel <= SEL_RF;
                ex_bubble <= 1'b1;
                if (!bus.flush && stall_count != '1)
                    stall_count <= stall_count + 1'b1;
            end else begin
                ex_v      <= bus.id_valid;
                ex_rw     <= bus.id_regwrite;
                ex_mr     <= bus.id_memread;
                ex_rd     <= bus.id_rd;
                fwd_a_sel <= bus.id_valid ? sel_a_c : SEL_RF;
                fwd_b_sel <= bus.id_valid ? sel_b_c : SEL_RF;
                ex_bubble <= ~bus.id_valid;
            end
        end
    end

    assign bus.stall       = stall_c;
    assign bus.ex_bubble   = ex_bubble;
    assign bus.fwd_a_sel   = fwd_a_sel;
    assign bus.fwd_b_sel   = fwd_b_sel;
    assign bus.stall_count = stall_count;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: ALU/distance-2 forwarding, load-use, x0, flush, and reset cases.
module tb_fwd_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fwd_hazard_if #(.REG_AW(5), .CNT_W(16)) bus ();

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one ID instruction; inputs change 1ns after the rising edge.
    task automatic id_drive(input logic v, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2,
                            input logic [4:0] rd, input logic rw, input logic mr,
                            input logic fl);
        bus.id_valid    = v;
        bus.id_rs1      = rs1;
        bus.id_use_rs1  = u1;
        bus.id_rs2      = rs2;
        bus.id_use_rs2  = u2;
        bus.id_rd       = rd;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        bus.flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        id_drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_fwd_a", bus.fwd_a_sel, 2'b00);
        chk("rst_fwd_b", bus.fwd_b_sel, 2'b00);
        chk("rst_bubble", bus.ex_bubble, 1'b1);
        chk("rst_count", bus.stall_count, 16'd0);
        chk("rst_stall", bus.stall, 1'b0);
        rst = 1'b0;

        // Back-to-back ALU hazard: add x5 then sub x8, x5, x6
        id_drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        #3 chk("alu_add_stall", bus.stall, 1'b0);
        tick();
        chk("alu_add_bubble", bus.ex_bubble, 1'b0);
        id_drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        #3 chk("alu_sub_stall", bus.stall, 1'b0);
        tick();
        chk("alu_fwd_a", bus.fwd_a_sel, 2'b01);
        chk("alu_fwd_b", bus.fwd_b_sel, 2'b00);

        // Distance-2: producer x7, independent x9, consumer rs2=7 (also writes x7)
        id_drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        id_drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        id_drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        chk("d2_fwd_b", bus.fwd_b_sel, 2'b10);
        chk("d2_fwd_a", bus.fwd_a_sel, 2'b00);
        // x7 in both EX and MEM: EX wins
        id_drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        id_drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b0, 1'b0, 1'b0);
        tick();
        chk("both_fwd_a", bus.fwd_a_sel, 2'b01);
        chk("both_fwd_b", bus.fwd_b_sel, 2'b00);

        // Load-use: lw x3, then add rs1=3
        id_drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        id_drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
        #3 chk("lu_stall_on", bus.stall, 1'b1);
        tick();
        chk("lu_bubble", bus.ex_bubble, 1'b1);
        chk("lu_bub_fwd_a", bus.fwd_a_sel, 2'b00);
        chk("lu_bub_fwd_b", bus.fwd_b_sel, 2'b00);
        chk("lu_count", bus.stall_count, 16'd1);
        #3 chk("lu_stall_off", bus.stall, 1'b0);
        tick();
        chk("lu_retry_fwd_a", bus.fwd_a_sel, 2'b10);
        chk("lu_retry_bubble", bus.ex_bubble, 1'b0);
        chk("lu_count_hold", bus.stall_count, 16'd1);

        // x0 immunity: lw x0 then reader of x0/x0
        id_drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        id_drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
        #3 chk("x0_stall", bus.stall, 1'b0);
        tick();
        chk("x0_fwd_a", bus.fwd_a_sel, 2'b00);
        chk("x0_fwd_b", bus.fwd_b_sel, 2'b00);
        chk("x0_bubble", bus.ex_bubble, 1'b0);

        // Flush overrides a load-use condition; lw x4 still moves on to MEM
        id_drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        id_drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b1);
        #3 chk("fl_stall", bus.stall, 1'b0);
        tick();
        chk("fl_bubble", bus.ex_bubble, 1'b1);
        chk("fl_count", bus.stall_count, 16'd1);
        chk("fl_fwd_a", bus.fwd_a_sel, 2'b00);
        id_drive(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0);
        #3 chk("fl_after_stall", bus.stall, 1'b0);
        tick();
        chk("fl_after_fwd_a", bus.fwd_a_sel, 2'b10);
        chk("fl_after_fwd_b", bus.fwd_b_sel, 2'b10);

        // Reset during a stall cycle
        id_drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        tick();
        id_drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
        #3 chk("rs_stall_pre", bus.stall, 1'b1);
        rst = 1'b1;
        #1 chk("rs_stall_gated", bus.stall, 1'b0);
        tick();
        chk("rs_fwd_a", bus.fwd_a_sel, 2'b00);
        chk("rs_fwd_b", bus.fwd_b_sel, 2'b00);
        chk("rs_bubble", bus.ex_bubble, 1'b1);
        chk("rs_count", bus.stall_count, 16'd0);
        rst = 1'b0;
        #3 chk("rs_stall_after", bus.stall, 1'b0);
        tick();
        chk("rs_after_fwd_a", bus.fwd_a_sel, 2'b00);
        chk("rs_after_bubble", bus.ex_bubble, 1'b0);
        chk("rs_after_count", bus.stall_count, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
